// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among NREQ writeback sources.
// Optional REGWR_ZERO_DISCARD_EN: grants targeting address 0 are acknowledged but never written.
module regfile_wr_arbiter #(
   parameter int NREQ = 3,
   parameter int AW   = 5,
   parameter int DW   = 64
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 hold,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*AW-1:0]   reqAddr,
   input  logic [NREQ*DW-1:0]   reqData,
   output logic [NREQ-1:0]      ack,
   output logic                 write,
   output logic [AW-1:0]        wrAddr,
   output logic [DW-1:0]        wrData,
   output logic [2:0]           grantId
);

   localparam int              PW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [PW:0]     NREQ_EXT = (PW+1)'(NREQ);
   localparam logic [PW-1:0]   LAST_IDX = PW'(NREQ - 1);

   logic [PW-1:0] ptrR;
   logic [PW-1:0] winS;
   logic          foundS;
   logic          hitS;
   logic [PW:0]   candS;
   logic [AW-1:0] selAddrS;
   logic [DW-1:0] selDataS;
   logic          writeEnS;

   function automatic logic [PW-1:0] advancePtr(input logic [PW-1:0] w);
      if (w == LAST_IDX) begin
         return {PW{1'b0}};
      end else begin
         return w + PW'(1);
      end
   endfunction

   // Round-robin search starting at ptrR; reset and hold suppress every grant.
   always_comb begin
      foundS = 1'b0;
      hitS   = 1'b0;
      winS   = {PW{1'b0}};
      candS  = {(PW+1){1'b0}};
      if (reset || hold) begin
         foundS = 1'b0;
      end else begin
         for (int k = 0; k < NREQ; k++) begin
            candS  = {1'b0, ptrR} + (PW+1)'(k);
            candS  = (candS >= NREQ_EXT) ? (candS - NREQ_EXT) : candS;
            hitS   = ~foundS & req[candS[PW-1:0]];
            winS   = hitS ? candS[PW-1:0] : winS;
            foundS = foundS | hitS;
         end
      end
   end

   // One-hot acknowledge for the winner.
   always_comb begin
      ack = {NREQ{1'b0}};
      if (foundS) begin
         ack = NREQ'(1) << winS;
      end else begin
         ack = {NREQ{1'b0}};
      end
   end

   // AND-OR mux of the winner's address and data, keyed by the one-hot ack.
   always_comb begin
      selAddrS = {AW{1'b0}};
      selDataS = {DW{1'b0}};
      for (int i = 0; i < NREQ; i++) begin
         selAddrS = selAddrS | ({AW{ack[i]}} & reqAddr[i*AW +: AW]);
         selDataS = selDataS | ({DW{ack[i]}} & reqData[i*DW +: DW]);
      end
   end

`ifdef REGWR_ZERO_DISCARD_EN
   assign writeEnS = foundS && (selAddrS != {AW{1'b0}});
`else
   assign writeEnS = foundS;
`endif

   // Register-file write port and round-robin pointer.
   always_ff @(posedge clk) begin
      if (reset) begin
         write   <= 1'b0;
         wrAddr  <= {AW{1'b0}};
         wrData  <= {DW{1'b0}};
         grantId <= 3'd0;
         ptrR    <= {PW{1'b0}};
      end else begin
         write <= writeEnS;
         if (writeEnS) begin
            wrAddr  <= selAddrS;
            wrData  <= selDataS;
            grantId <= 3'(winS);
         end
         // A discarded address-0 grant still advances the pointer.
         if (foundS) begin
            ptrR <= advancePtr(winS);
         end
      end
   end

endmodule
